// File: rtl/mmio_uart_ctrl_pkg.sv
// Shared MMIO definitions: register offsets, status bit positions and the status word layout.
// Also used by the core-side decode logic.
package mmio_uart_ctrl_pkg;

  typedef enum logic [7:0] {
    MMIO_STATUS  = 8'h00,
    MMIO_RXDATA  = 8'h04,
    MMIO_TXDATA  = 8'h08,
    MMIO_CYCLE   = 8'h10,
    MMIO_INSTRET = 8'h14,
    MMIO_CNTCLR  = 8'h18
  } mmio_off_e;

  localparam int unsigned STAT_TX_SPACE = 0;
  localparam int unsigned STAT_RX_AVAIL = 1;
  localparam int unsigned STAT_OVF      = 2;

  function automatic logic [31:0] status_word(input logic ovf, input logic rx_avail,
                                              input logic tx_space);
    logic [31:0] w;
    w = '0;
    w[STAT_OVF]      = ovf;
    w[STAT_RX_AVAIL] = rx_avail;
    w[STAT_TX_SPACE] = tx_space;
    return w;
  endfunction

endpackage

// File: rtl/mmio_uart_ctrl_if.sv
// Bus bundle between the core load/store path, the UART and the MMIO controller.
// The slave modport is the controller's view.
interface mmio_uart_ctrl_if;
  logic        mmio_en;
  logic        mmio_we;
  logic [7:0]  mmio_addr;
  logic [31:0] mmio_wdata;
  logic [31:0] mmio_rdata;
  logic        mmio_err;
  logic        instret;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;

  modport master (
    output mmio_en, mmio_we, mmio_addr, mmio_wdata, instret, rx_data, rx_valid, tx_ready,
    input  mmio_rdata, mmio_err, rx_ready, tx_data, tx_valid
  );

  modport slave (
    input  mmio_en, mmio_we, mmio_addr, mmio_wdata, instret, rx_data, rx_valid, tx_ready,
    output mmio_rdata, mmio_err, rx_ready, tx_data, tx_valid
  );
endinterface

// File: rtl/mmio_uart_ctrl_byte_fifo.sv
// byte_fifo: power-of-two synchronous FIFO with async active-low reset.
// A push while full is dropped even if a pop happens in the same cycle.
module byte_fifo
  import mmio_uart_ctrl_pkg::*;
#(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_din,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_dout,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [AW:0]      r_count;
  logic             w_push;
  logic             w_pop;

  assign o_full  = (r_count == (AW+1)'(DEPTH));
  assign o_empty = (r_count == '0);
  assign w_push  = i_push & ~o_full;
  assign w_pop   = i_pop & ~o_empty;
  assign o_dout  = r_mem[r_rptr];
  assign o_count = r_count;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= r_rptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= i_din;
  end

endmodule

// File: rtl/mmio_uart_ctrl.sv
// MMIO controller: register decode, UART rx/tx handshakes, TX FIFO, cycle/instret counters.
// Define MMIO_RX_FIFO_EN to replace the single-byte RX holding register with an RX FIFO.
module mmio_uart_ctrl
  import mmio_uart_ctrl_pkg::*;
#(
  parameter int unsigned TX_DEPTH  = 8,
  parameter int unsigned RX_DEPTH  = 8,
  parameter int unsigned CNT_WIDTH = 32
) (
  input  logic              clk,
  input  logic              rst,
  mmio_uart_ctrl_if.slave   bus
);
  localparam int unsigned TXCW = $clog2(TX_DEPTH) + 1;

  if (TX_DEPTH < 2 || (TX_DEPTH & (TX_DEPTH - 1)) != 0 ||
      RX_DEPTH < 2 || (RX_DEPTH & (RX_DEPTH - 1)) != 0 ||
      CNT_WIDTH == 0 || CNT_WIDTH > 32) begin : g_bad_cfg
    $error("mmio_uart_ctrl: unsupported parameter set");
  end

  logic [31:0]          r_rdata;
  logic                 r_err;
  logic                 r_ovf;
  logic [CNT_WIDTH-1:0] r_cycle;
  logic [CNT_WIDTH-1:0] r_instret;

  logic            w_load;
  logic            w_store;
  logic            w_bad;
  logic [31:0]     w_rd_val;
  logic            w_tx_push;
  logic            w_tx_pop;
  logic            w_tx_full;
  logic            w_tx_empty;
  logic [7:0]      w_tx_head;
  logic [TXCW-1:0] w_tx_count;
  logic            w_tx_space;
  logic            w_rx_pop;
  logic            w_rx_empty;
  logic [7:0]      w_rx_head;
  logic            w_ovf_clr;
  logic            w_cnt_clr;
  logic            w_unused;

  assign w_load     = bus.mmio_en & ~bus.mmio_we;
  assign w_store    = bus.mmio_en & bus.mmio_we;
  assign w_tx_space = (w_tx_count != TXCW'(TX_DEPTH));
  assign w_unused   = &{1'b0, bus.mmio_wdata[31:8]};

  always_comb begin
    w_bad     = 1'b0;
    w_rd_val  = '0;
    w_tx_push = 1'b0;
    w_rx_pop  = 1'b0;
    w_ovf_clr = 1'b0;
    w_cnt_clr = 1'b0;
    if (w_load) begin
      case (bus.mmio_addr)
        MMIO_STATUS:  w_rd_val = status_word(r_ovf, ~w_rx_empty, w_tx_space);
        MMIO_RXDATA: begin
          w_rx_pop = ~w_rx_empty;
          w_rd_val = w_rx_empty ? 32'h0 : {24'h0, w_rx_head};
        end
        MMIO_CYCLE:   w_rd_val = 32'(r_cycle);
        MMIO_INSTRET: w_rd_val = 32'(r_instret);
        default:      w_bad = 1'b1;
      endcase
    end else if (w_store) begin
      case (bus.mmio_addr)
        MMIO_STATUS: w_ovf_clr = bus.mmio_wdata[STAT_OVF];
        MMIO_TXDATA: w_tx_push = 1'b1;
        MMIO_CNTCLR: w_cnt_clr = 1'b1;
        default:     w_bad = 1'b1;
      endcase
    end
  end

  // rdata holds across good stores and idle cycles; a bad access of either kind forces it to 0.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rdata <= '0;
      r_err   <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      if (w_load || w_bad) r_rdata <= w_rd_val;
      r_err <= w_bad;
      if (w_tx_push && w_tx_full) r_ovf <= 1'b1;
      else if (w_ovf_clr)         r_ovf <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cycle   <= '0;
      r_instret <= '0;
    end else if (w_cnt_clr) begin
      r_cycle   <= '0;
      r_instret <= '0;
    end else begin
      r_cycle <= r_cycle + CNT_WIDTH'(1);
      if (bus.instret) r_instret <= r_instret + CNT_WIDTH'(1);
    end
  end

  assign w_tx_pop     = ~w_tx_empty & bus.tx_ready;
  assign bus.tx_valid = ~w_tx_empty;
  assign bus.tx_data  = w_tx_head;

  byte_fifo #(
    .DEPTH (TX_DEPTH),
    .WIDTH (8)
  ) u_tx_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_tx_push),
    .i_din   (bus.mmio_wdata[7:0]),
    .i_pop   (w_tx_pop),
    .o_dout  (w_tx_head),
    .o_full  (w_tx_full),
    .o_empty (w_tx_empty),
    .o_count (w_tx_count)
  );

`ifdef MMIO_RX_FIFO_EN
  logic                      w_rx_full;
  logic [$clog2(RX_DEPTH):0] w_rx_count;
  logic                      w_unused_rx;

  assign bus.rx_ready = ~w_rx_full;
  assign w_unused_rx  = &{1'b0, w_rx_count};

  byte_fifo #(
    .DEPTH (RX_DEPTH),
    .WIDTH (8)
  ) u_rx_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (bus.rx_valid & ~w_rx_full),
    .i_din   (bus.rx_data),
    .i_pop   (w_rx_pop),
    .o_dout  (w_rx_head),
    .o_full  (w_rx_full),
    .o_empty (w_rx_empty),
    .o_count (w_rx_count)
  );
`else
  logic       r_rx_held;
  logic [7:0] r_rx_byte;

  assign bus.rx_ready = ~r_rx_held;
  assign w_rx_empty   = ~r_rx_held;
  assign w_rx_head    = r_rx_byte;

  // A byte offered while held is not acknowledged, so it waits in the receiver.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rx_held <= 1'b0;
      r_rx_byte <= '0;
    end else if (bus.rx_valid && !r_rx_held) begin
      r_rx_held <= 1'b1;
      r_rx_byte <= bus.rx_data;
    end else if (w_rx_pop) begin
      r_rx_held <= 1'b0;
    end
  end
`endif

  assign bus.mmio_rdata = r_rdata;
  assign bus.mmio_err   = r_err;

endmodule

// File: tb/tb_mmio_uart_ctrl.sv
// Directed self-checking bench for mmio_uart_ctrl with hand-computed expectations.
// Extra RX FIFO checks are compiled in when MMIO_RX_FIFO_EN is defined.
module tb_mmio_uart_ctrl;
  import mmio_uart_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  mmio_uart_ctrl_if bus ();

  mmio_uart_ctrl #(
    .TX_DEPTH  (8),
    .RX_DEPTH  (8),
    .CNT_WIDTH (32)
  ) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int unsigned n_chk  = 0;
  int unsigned n_pass = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  task automatic bus_op(input logic we, input logic [7:0] addr, input logic [31:0] wd,
                        input logic ins, output logic [31:0] rdata, output logic err);
    @(negedge clk);
    bus.mmio_en    = 1'b1;
    bus.mmio_we    = we;
    bus.mmio_addr  = addr;
    bus.mmio_wdata = wd;
    bus.instret    = ins;
    @(posedge clk);
    #1;
    rdata          = bus.mmio_rdata;
    err            = bus.mmio_err;
    bus.mmio_en    = 1'b0;
    bus.mmio_we    = 1'b0;
    bus.instret    = 1'b0;
  endtask

  task automatic rd_chk(input string tag, input logic [7:0] addr, input logic [31:0] exp,
                        input logic exp_err);
    logic [31:0] d;
    logic        e;
    bus_op(1'b0, addr, 32'h0, 1'b0, d, e);
    check({tag, ".data"}, d, exp);
    check({tag, ".err"}, {31'h0, e}, {31'h0, exp_err});
  endtask

  task automatic wr_chk(input string tag, input logic [7:0] addr, input logic [31:0] wd,
                        input logic ins, input logic exp_err);
    logic [31:0] d;
    logic        e;
    bus_op(1'b1, addr, wd, ins, d, e);
    check({tag, ".err"}, {31'h0, e}, {31'h0, exp_err});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    bus.mmio_en    = 1'b0;
    bus.mmio_we    = 1'b0;
    bus.mmio_addr  = '0;
    bus.mmio_wdata = '0;
    bus.instret    = 1'b0;
    bus.rx_data    = '0;
    bus.rx_valid   = 1'b0;
    bus.tx_ready   = 1'b0;

    // Reset state, then 3 idle cycles before the cycle-count load.
    repeat (2) @(negedge clk);
    check("rst.rdata", bus.mmio_rdata, 32'h0);
    check("rst.err", {31'h0, bus.mmio_err}, 32'h0);
    check("rst.tx_valid", {31'h0, bus.tx_valid}, 32'h0);
    rst = 1'b1;
    #1;
    check("rst.rx_ready", {31'h0, bus.rx_ready}, 32'h1);
    repeat (3) @(posedge clk);
    rd_chk("t1.cycle", MMIO_CYCLE, 32'd3, 1'b0);
    rd_chk("t1.status", MMIO_STATUS, 32'h1, 1'b0);

    // TX overflow with the transmitter stalled, then drain in order.
    for (int i = 0; i < 9; i++) wr_chk("t2.push", MMIO_TXDATA, 32'h41 + 32'(i), 1'b0, 1'b0);
    check("t2.tx_valid", {31'h0, bus.tx_valid}, 32'h1);
    check("t2.tx_head", {24'h0, bus.tx_data}, 32'h41);
    rd_chk("t2.status_full", MMIO_STATUS, 32'h4, 1'b0);
    @(negedge clk);
    bus.tx_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      check("t2.drain_valid", {31'h0, bus.tx_valid}, 32'h1);
      check("t2.drain_data", {24'h0, bus.tx_data}, 32'h41 + 32'(i));
      @(negedge clk);
    end
    check("t2.drained", {31'h0, bus.tx_valid}, 32'h0);
    bus.tx_ready = 1'b0;
    rd_chk("t2.status_ovf", MMIO_STATUS, 32'h5, 1'b0);
    wr_chk("t2.ovf_clr", MMIO_STATUS, 32'h4, 1'b0, 1'b0);
    rd_chk("t2.status_clr", MMIO_STATUS, 32'h1, 1'b0);

    // Single received byte, then read of an empty RX path.
    @(negedge clk);
    bus.rx_valid = 1'b1;
    bus.rx_data  = 8'h5A;
    @(negedge clk);
    bus.rx_valid = 1'b0;
`ifndef MMIO_RX_FIFO_EN
    check("t3.rx_ready_held", {31'h0, bus.rx_ready}, 32'h0);
`endif
    rd_chk("t3.status_avail", MMIO_STATUS, 32'h3, 1'b0);
    rd_chk("t3.rxdata", MMIO_RXDATA, 32'h5A, 1'b0);
    rd_chk("t3.status_empty", MMIO_STATUS, 32'h1, 1'b0);
    check("t3.rx_ready", {31'h0, bus.rx_ready}, 32'h1);
    rd_chk("t3.rx_empty", MMIO_RXDATA, 32'h0, 1'b0);

`ifndef MMIO_RX_FIFO_EN
    // Second byte stays pending in the receiver until the held byte is read.
    @(negedge clk);
    bus.rx_valid = 1'b1;
    bus.rx_data  = 8'h11;
    @(negedge clk);
    bus.rx_data  = 8'h22;
    check("t3.pend_ready", {31'h0, bus.rx_ready}, 32'h0);
    rd_chk("t3.pend_first", MMIO_RXDATA, 32'h11, 1'b0);
    @(posedge clk);
    #1;
    bus.rx_valid = 1'b0;
    rd_chk("t3.pend_second", MMIO_RXDATA, 32'h22, 1'b0);
    rd_chk("t3.pend_status", MMIO_STATUS, 32'h1, 1'b0);
`endif

    // instret counting and clear-wins-over-increment.
    @(negedge clk);
    bus.instret = 1'b1;
    repeat (10) @(negedge clk);
    bus.instret = 1'b0;
    rd_chk("t4.instret", MMIO_INSTRET, 32'd10, 1'b0);
    wr_chk("t4.clr", MMIO_CNTCLR, 32'h0, 1'b1, 1'b0);
    rd_chk("t4.instret_clr", MMIO_INSTRET, 32'd0, 1'b0);
    rd_chk("t4.cycle_clr", MMIO_CYCLE, 32'd1, 1'b0);

    // Error responses.
    rd_chk("t5.unmapped", 8'h20, 32'h0, 1'b1);
    rd_chk("t5.err_drop", MMIO_STATUS, 32'h1, 1'b0);
    rd_chk("t5.rd_wo", MMIO_TXDATA, 32'h0, 1'b1);
    wr_chk("t5.wr_ro_rx", MMIO_RXDATA, 32'h0, 1'b0, 1'b1);
    wr_chk("t5.clr", MMIO_CNTCLR, 32'h0, 1'b0, 1'b0);
    wr_chk("t5.wr_ro_cycle", MMIO_CYCLE, 32'h0000FFFF, 1'b0, 1'b1);
    rd_chk("t5.cycle_kept", MMIO_CYCLE, 32'd1, 1'b0);

    // Asynchronous reset with TX bytes queued.
    for (int i = 0; i < 4; i++) wr_chk("t6.push", MMIO_TXDATA, 32'h71 + 32'(i), 1'b0, 1'b0);
    check("t6.tx_valid", {31'h0, bus.tx_valid}, 32'h1);
    rd_chk("t6.status", MMIO_STATUS, 32'h1, 1'b0);
    @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    check("t6.async_tx_valid", {31'h0, bus.tx_valid}, 32'h0);
    check("t6.async_rdata", bus.mmio_rdata, 32'h0);
    @(negedge clk);
    rst           = 1'b1;
    bus.mmio_en   = 1'b1;
    bus.mmio_we   = 1'b0;
    bus.mmio_addr = MMIO_CYCLE;
    @(posedge clk);
    #1;
    bus.mmio_en = 1'b0;
    check("t6.cycle_after_rst", bus.mmio_rdata, 32'h0);
    rd_chk("t6.instret_after_rst", MMIO_INSTRET, 32'h0, 1'b0);
    rd_chk("t6.status_after_rst", MMIO_STATUS, 32'h1, 1'b0);
    check("t6.tx_idle", {31'h0, bus.tx_valid}, 32'h0);

`ifdef MMIO_RX_FIFO_EN
    // Nine offered bytes: the ninth is refused while the FIFO is full.
    for (int i = 0; i < 9; i++) begin
      bus.rx_data  = 8'h61 + 8'(i);
      bus.rx_valid = 1'b1;
      @(negedge clk);
    end
    bus.rx_valid = 1'b0;
    check("t6.rx_full_ready", {31'h0, bus.rx_ready}, 32'h0);
    rd_chk("t6.rx_status", MMIO_STATUS, 32'h3, 1'b0);
    for (int i = 0; i < 8; i++) rd_chk("t6.rx_fifo", MMIO_RXDATA, 32'h61 + 32'(i), 1'b0);
    rd_chk("t6.rx_drained", MMIO_STATUS, 32'h1, 1'b0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
